// File: rtl/wb_burst_reader_pkg.sv
// Shared Wishbone cycle-type codes and the burst reader's state encoding.
package wb_burst_reader_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SPACE,
    BURST,
    FINISH
  } state_t;

endpackage

// File: rtl/wb_burst_reader_fifo.sv
// Synchronous FIFO with registered occupancy count; head word is shown combinationally.
module sync_fifo #(
  parameter int width = 32,
  parameter int depth = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [width-1:0]             push_data,
  input  logic                         pop,
  output logic [width-1:0]             pop_data,
  output logic [$clog2(depth+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int AW = (depth > 1) ? $clog2(depth) : 1;
  localparam int CW = $clog2(depth + 1);

  logic [width-1:0] mem [depth];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(depth - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full     = (count == CW'(depth));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      // Simultaneous push and pop leaves the count unchanged.
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_burst_reader.sv
// Wishbone B3 read master: streams a contiguous word region out of a slave in
// linear incrementing bursts and presents the words as a valid/ready stream.
module wb_burst_reader
  import wb_burst_reader_pkg::*;
#(
  parameter int burst_len  = 8,
  parameter int fifo_depth = 16,
  parameter int lw         = 16
) (
  input  logic          wb_clk,
  input  logic          wb_rst,
  input  logic          start,
  input  logic [31:0]   base_adr,
  input  logic [lw-1:0] len_words,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [31:0]   wbm_adr_o,
  output logic [2:0]    wbm_cti_o,
  output logic [1:0]    wbm_bte_o,
  output logic          wbm_we_o,
  output logic [3:0]    wbm_sel_o,
  output logic          wbm_cyc_o,
  output logic          wbm_stb_o,
  input  logic [31:0]   wbm_dat_i,
  input  logic          wbm_ack_i,
  input  logic          wbm_err_i,
  input  logic          wbm_rty_i,
  output logic [31:0]   dout_data,
  output logic          dout_valid,
  input  logic          dout_ready
);

  localparam int BW = $clog2(burst_len + 1);
  localparam int CW = $clog2(fifo_depth + 1);

  state_t          state;
  logic [lw-1:0]   remaining;
  logic [BW-1:0]   beat_cnt, beats;
  logic [CW-1:0]   fifo_count;
  logic            fifo_full, fifo_empty;
  logic            push, pop, space_ok;

  assign wbm_bte_o  = BTE_LINEAR;
  assign wbm_we_o   = 1'b0;
  assign wbm_sel_o  = 4'hF;
  assign dout_valid = ~fifo_empty;
  assign pop        = dout_valid & dout_ready;
  assign push       = (state == BURST) & wbm_ack_i & ~wbm_err_i & ~wbm_rty_i & ~fifo_full;

  always_comb begin
    beats = BW'(burst_len);
    if (remaining < lw'(burst_len)) beats = BW'(remaining);
  end

  // Registered count only: a pop in this same cycle is not credited as space.
  assign space_ok = (CW'(fifo_depth) - fifo_count) >= CW'(beats);

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_adr_o <= '0;
      wbm_cti_o <= CTI_CLASSIC;
      remaining <= '0;
      beat_cnt  <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (len_words != '0) begin
              wbm_adr_o <= base_adr & ~32'h3;
              remaining <= len_words;
              error     <= 1'b0;
              busy      <= 1'b1;
              state     <= WAIT_SPACE;
            end else begin
              done <= 1'b1;
            end
          end
        end
        WAIT_SPACE: begin
          if (space_ok) begin
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_cti_o <= (beats == BW'(1)) ? CTI_CLASSIC : CTI_INC;
            beat_cnt  <= beats;
            state     <= BURST;
          end
        end
        BURST: begin
          if (wbm_err_i || wbm_rty_i) begin
            error     <= 1'b1;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_cti_o <= CTI_CLASSIC;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= FINISH;
          end else if (wbm_ack_i) begin
            wbm_adr_o <= wbm_adr_o + 32'd4;
            remaining <= remaining - lw'(1);
            beat_cnt  <= beat_cnt - BW'(1);
            if (beat_cnt == BW'(1)) begin
              wbm_cyc_o <= 1'b0;
              wbm_stb_o <= 1'b0;
              wbm_cti_o <= CTI_CLASSIC;
              if (remaining == lw'(1)) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= FINISH;
              end else begin
                state <= WAIT_SPACE;
              end
            end else if (beat_cnt == BW'(2)) begin
              wbm_cti_o <= CTI_EOB;
            end
          end
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  sync_fifo #(
    .width(32),
    .depth(fifo_depth)
  ) u_fifo (
    .clk       (wb_clk),
    .rst       (wb_rst),
    .push      (push),
    .push_data (wbm_dat_i),
    .pop       (pop),
    .pop_data  (dout_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_wb_burst_reader.sv
// Bench for wb_burst_reader: ROM slave model, burst/stream scoreboard, directed transfers.
module tb_wb_burst_reader;

  localparam int BL = 8;
  localparam int FD = 16;

  logic        wb_clk = 1'b0, wb_rst = 1'b1, start = 1'b0;
  logic [31:0] base_adr = '0;
  logic [15:0] len_words = '0;
  logic        busy, done, error;
  logic [31:0] wbm_adr_o;
  logic [2:0]  wbm_cti_o;
  logic [1:0]  wbm_bte_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_cyc_o, wbm_stb_o;
  logic [31:0] wbm_dat_i = '0;
  logic        wbm_ack_i = 1'b0, wbm_err_i = 1'b0, wbm_rty_i = 1'b0;
  logic [31:0] dout_data;
  logic        dout_valid;
  logic        dout_ready = 1'b1;

  wb_burst_reader #(.burst_len(BL), .fifo_depth(FD), .lw(16)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .start(start), .base_adr(base_adr),
    .len_words(len_words), .busy(busy), .done(done), .error(error),
    .wbm_adr_o(wbm_adr_o), .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o),
    .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o), .wbm_cyc_o(wbm_cyc_o),
    .wbm_stb_o(wbm_stb_o), .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i),
    .wbm_err_i(wbm_err_i), .wbm_rty_i(wbm_rty_i), .dout_data(dout_data),
    .dout_valid(dout_valid), .dout_ready(dout_ready)
  );

  always #5 wb_clk = ~wb_clk;

  int total = 0, bad = 0;
  int cycles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rom(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  // Expected bus beats and stream words for the transfer in flight.
  logic [31:0] exp_adr[$];
  logic [31:0] exp_dat[$];
  logic [2:0]  exp_cti[$];

  task automatic load_model(input logic [31:0] base, input int len, input int nbeats);
    logic [31:0] b, a;
    int bs, sz, pos;
    b = base & ~32'h3;
    for (int i = 0; i < nbeats; i++) begin
      bs  = (i / BL) * BL;
      sz  = (len - bs < BL) ? len - bs : BL;
      pos = i - bs;
      a   = b + 32'(4 * i);
      exp_adr.push_back(a);
      exp_dat.push_back(rom(a));
      exp_cti.push_back(sz == 1 ? 3'b000 : (pos == sz - 1 ? 3'b111 : 3'b010));
    end
  endtask

  // ROM slave: slow mode answers every other cycle, fast mode answers back-to-back.
  logic fast = 1'b0, use_rty = 1'b0;
  int   err_at = 0;
  int   slv_total = 0;

  always @(posedge wb_clk) begin
    if (wb_rst) begin
      wbm_ack_i <= 1'b0;
      wbm_err_i <= 1'b0;
      wbm_rty_i <= 1'b0;
    end else begin
      wbm_ack_i <= 1'b0;
      wbm_err_i <= 1'b0;
      wbm_rty_i <= 1'b0;
      if (wbm_cyc_o && wbm_stb_o && !wbm_err_i && !wbm_rty_i &&
          (fast ? !(wbm_ack_i && (wbm_cti_o == 3'b111 || wbm_cti_o == 3'b000)) : !wbm_ack_i)) begin
        slv_total <= slv_total + 1;
        if (slv_total + 1 == err_at) begin
          if (use_rty) wbm_rty_i <= 1'b1;
          else         wbm_err_i <= 1'b1;
        end else begin
          wbm_ack_i <= 1'b1;
          wbm_dat_i <= rom(wbm_ack_i ? wbm_adr_o + 32'd4 : wbm_adr_o);
        end
      end
    end
  end

  always @(posedge wb_clk) cycles <= cycles + 1;

  int          acks = 0, pops = 0, bursts = 0, dones = 0, occ = 0, burst_beats = 0, last_rise = 0;
  logic [31:0] last_adr = '0, last_pop = '0;
  logic [2:0]  last_cti = '0;
  logic        prev_cyc = 1'b0;

  always @(negedge wb_clk) begin
    if (wb_rst) begin
      exp_adr.delete();
      exp_dat.delete();
      exp_cti.delete();
      occ = 0;
    end else begin
      if (wbm_cyc_o) begin
        check("bus_static", {wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_bte_o}, {1'b1, 1'b0, 4'hF, 2'b00});
        if (!prev_cyc) begin
          bursts++;
          burst_beats = 0;
          last_rise = cycles;
        end
        if (wbm_ack_i) begin
          acks++;
          occ++;
          burst_beats++;
          check("burst_len", 32'(burst_beats <= BL), 1);
          check("fifo_bound", 32'(occ <= FD), 1);
          check("beat_expected", 32'(exp_adr.size() != 0), 1);
          if (exp_adr.size() != 0) begin
            check("adr", wbm_adr_o, exp_adr.pop_front());
            check("cti", 32'(wbm_cti_o), 32'(exp_cti.pop_front()));
          end
          last_adr = wbm_adr_o;
          last_cti = wbm_cti_o;
        end
      end else begin
        check("stb_idle", 32'(wbm_stb_o), 0);
      end
      if (dout_valid && dout_ready) begin
        pops++;
        occ--;
        check("word_expected", 32'(exp_dat.size() != 0), 1);
        if (exp_dat.size() != 0) check("dout_data", dout_data, exp_dat.pop_front());
        last_pop = dout_data;
      end else if (dout_valid && exp_dat.size() != 0) begin
        check("dout_hold", dout_data, exp_dat[0]);
      end
      if (done) dones++;
    end
    prev_cyc = wbm_cyc_o;
  end

  int t0 = 0;

  task automatic start_xfer(input logic [31:0] base, input int len, input int nb);
    load_model(base, len, nb);
    @(posedge wb_clk); #1;
    base_adr = base; len_words = 16'(len); start = 1'b1; t0 = cycles;
    @(posedge wb_clk); #1;
    start = 1'b0;
    check("busy_on_start", 32'(busy), 1);
    check("error_cleared", 32'(error), 0);
  endtask

  task automatic wait_end(input int d0);
    int n;
    n = 0;
    while (dones == d0 && n < 3000) begin @(posedge wb_clk); #1; n++; end
    n = 0;
    while ((exp_dat.size() != 0 || dout_valid) && n < 3000) begin @(posedge wb_clk); #1; n++; end
    check("beats_left", 32'(exp_adr.size()), 0);
    check("words_left", 32'(exp_dat.size()), 0);
    check("done_count", 32'(dones - d0), 1);
    check("busy_after", 32'(busy), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  int a0, b0, d0, n;

  initial begin
    repeat (3) @(posedge wb_clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_error", 32'(error), 0);
    check("rst_cyc", 32'(wbm_cyc_o), 0);
    check("rst_adr", wbm_adr_o, 0);
    check("rst_cti", 32'(wbm_cti_o), 0);
    check("rst_valid", 32'(dout_valid), 0);
    wb_rst = 1'b0;

    // One full burst of 8 from 0x100.
    a0 = acks; b0 = bursts; d0 = dones;
    start_xfer(32'h100, 8, 8);
    wait_end(d0);
    check("t1_bursts", 32'(bursts - b0), 1);
    check("t1_acks", 32'(acks - a0), 8);
    check("t1_latency", 32'(last_rise - t0), 2);
    check("t1_last_adr", last_adr, 32'h11C);
    check("t1_last_cti", 32'(last_cti), 3'b111);
    check("t1_last_word", last_pop, 32'hFEE3011C);
    check("t1_error", 32'(error), 0);

    // 20 words with a back-to-back slave: bursts of 8, 8, 4.
    fast = 1'b1;
    a0 = acks; b0 = bursts; d0 = dones;
    start_xfer(32'h400, 20, 20);
    wait_end(d0);
    check("t2_bursts", 32'(bursts - b0), 3);
    check("t2_acks", 32'(acks - a0), 20);
    check("t2_last_adr", last_adr, 32'h44C);
    check("t2_last_cti", 32'(last_cti), 3'b111);
    fast = 1'b0;

    // Single classic cycle; low address bits are dropped.
    a0 = acks; b0 = bursts; d0 = dones;
    start_xfer(32'h2003, 1, 1);
    wait_end(d0);
    check("t3_bursts", 32'(bursts - b0), 1);
    check("t3_adr", last_adr, 32'h2000);
    check("t3_cti", 32'(last_cti), 3'b000);
    check("t3_word", last_pop, 32'hDFFF2000);

    // Consumer stalled: two bursts fill the FIFO, then the master waits.
    dout_ready = 1'b0;
    a0 = acks; b0 = bursts; d0 = dones;
    start_xfer(32'h800, 32, 32);
    repeat (100) @(posedge wb_clk);
    #1;
    check("t4_stall_acks", 32'(acks - a0), 16);
    check("t4_stall_bursts", 32'(bursts - b0), 2);
    check("t4_stall_cyc", 32'(wbm_cyc_o), 0);
    check("t4_stall_busy", 32'(busy), 1);
    check("t4_stall_valid", 32'(dout_valid), 1);
    check("t4_stall_head", dout_data, 32'hF7FF0800);
    dout_ready = 1'b1;
    wait_end(d0);
    check("t4_acks", 32'(acks - a0), 32);
    check("t4_bursts", 32'(bursts - b0), 4);

    // Address wraps past 2^32.
    fast = 1'b1;
    b0 = bursts; d0 = dones;
    start_xfer(32'hFFFF_FFF8, 4, 4);
    wait_end(d0);
    check("t5_bursts", 32'(bursts - b0), 1);
    check("t5_last_adr", last_adr, 32'h4);
    fast = 1'b0;

    // err on beat 3 of 8: two words survive, error sticks.
    err_at = slv_total + 3;
    a0 = acks; b0 = bursts; d0 = dones;
    start_xfer(32'h300, 8, 2);
    wait_end(d0);
    err_at = 0;
    check("t6_error", 32'(error), 1);
    check("t6_acks", 32'(acks - a0), 2);
    check("t6_bursts", 32'(bursts - b0), 1);
    check("t6_cyc", 32'(wbm_cyc_o), 0);
    check("t6_last_word", last_pop, 32'hFCFB0304);
    repeat (3) @(posedge wb_clk);
    #1;
    check("t6_sticky", 32'(error), 1);

    // Next start clears the error.
    d0 = dones;
    start_xfer(32'h500, 2, 2);
    wait_end(d0);
    check("t7_error", 32'(error), 0);

    // rty on the first beat is an error too.
    use_rty = 1'b1;
    err_at = slv_total + 1;
    a0 = acks; d0 = dones;
    start_xfer(32'h600, 4, 0);
    wait_end(d0);
    err_at = 0;
    use_rty = 1'b0;
    check("t8_error", 32'(error), 1);
    check("t8_acks", 32'(acks - a0), 0);

    // Reset in the middle of a burst.
    a0 = acks;
    start_xfer(32'h700, 16, 16);
    n = 0;
    while (acks < a0 + 3 && n < 200) begin @(posedge wb_clk); #1; n++; end
    check("t9_reached_beat3", 32'(acks >= a0 + 3), 1);
    wb_rst = 1'b1;
    @(posedge wb_clk); #1;
    wb_rst = 1'b0;
    check("t9_cyc", 32'(wbm_cyc_o), 0);
    check("t9_valid", 32'(dout_valid), 0);
    check("t9_busy", 32'(busy), 0);
    check("t9_error", 32'(error), 0);

    // Zero-length start: done only, no bus activity.
    b0 = bursts; d0 = dones;
    @(posedge wb_clk); #1;
    base_adr = 32'h900; len_words = 16'd0; start = 1'b1;
    @(posedge wb_clk); #1;
    start = 1'b0;
    check("t10_done", 32'(done), 1);
    check("t10_busy", 32'(busy), 0);
    @(posedge wb_clk); #1;
    check("t10_done_pulse", 32'(done), 0);
    repeat (5) @(posedge wb_clk);
    #1;
    check("t10_dones", 32'(dones - d0), 1);
    check("t10_bursts", 32'(bursts - b0), 0);
    check("t10_cyc", 32'(wbm_cyc_o), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_burst_reader.md
Name: wb_burst_reader

Overview:
- Wishbone B3 read master that streams a contiguous word region out of a Wishbone slave, typically the boot ROM, into a valid/ready stream.
- Issues linear incrementing bursts: cti 010 on every beat except the last, which carries 111; bte 00.
- Buffers returned words in an internal FIFO.
- Sits directly upstream of the ROM slave. Feeds a boot loader / RAM copier downstream.

Parameters:
- burst_len, 8, max beats per burst; power of 2, >=1.
- fifo_depth, 16, output FIFO words; power of 2, >= burst_len.
- lw, 16, width of the length input (words).

Ports:
- wb_clk  in  1  clock
- wb_rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; latch base_adr/len_words; ignored while busy
- base_adr  in  32  byte address; bits [1:0] forced to 0
- len_words  in  lw  number of 32-bit words to read
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse at end of transfer (normal or aborted)
- error  out  1  sticky until next accepted start; set on err/rty
- wbm_adr_o  out  32  word-aligned address
- wbm_cti_o  out  3  cycle type
- wbm_bte_o  out  2  always 00
- wbm_we_o  out  1  always 0
- wbm_sel_o  out  4  always 1111
- wbm_cyc_o  out  1  bus cycle
- wbm_stb_o  out  1  strobe; equals wbm_cyc_o
- wbm_dat_i  in  32  read data
- wbm_ack_i  in  1  acknowledge
- wbm_err_i  in  1  error
- wbm_rty_i  in  1  retry; treated as error
- dout_data  out  32  stream data, FIFO head
- dout_valid  out  1  FIFO non-empty
- dout_ready  in  1  consumer accepts when valid & ready

Behaviour:
- Reset values: busy, done, error, cyc, stb = 0; adr = 0; cti = 000; FIFO emptied; dout_valid = 0; state IDLE. Reset mid-burst drops cyc at the reset edge. Discarded data is not delivered.
- States: IDLE, WAIT_SPACE, BURST, FINISH.
- IDLE: start with len_words != 0 -> latch address and remaining count; clear error; busy = 1; go to WAIT_SPACE. start with len_words == 0 -> done pulses the next cycle, no bus activity, busy stays 0.
- WAIT_SPACE: beats = min(burst_len, remaining). Proceed when FIFO free >= beats, where free = fifo_depth - count. Free is evaluated with registered count, so a same-cycle pop is not credited. Next cycle: cyc = stb = 1; go to BURST.
- BURST, cti encoding:
  - beats == 1 -> cti 000 (classic).
  - beats > 1 -> cti 010 until the beat before the last ack; 111 on the final beat.
- BURST, per ack: push wbm_dat_i into the FIFO; adr += 4; remaining -= 1; beat count -= 1.
  - On the final ack, cyc/stb deassert at the next edge. At least one idle cycle separates bursts.
  - Then go to WAIT_SPACE if remaining != 0, else FINISH.
- FIFO never overflows: space is reserved before the burst starts.
- err or rty during BURST: error = 1; cyc drops next edge; the word is not pushed; go to FINISH. Words already in the FIFO remain deliverable.
- FINISH: done = 1 for one cycle; busy = 0; go to IDLE. done is not gated on the FIFO draining.
- Address wraps modulo 2^32. No boundary splitting is required.
- Simultaneous push and pop in the same cycle: count unchanged.
- Latency: start -> first stb is 2 cycles when the FIFO has space. ack -> dout_valid is 1 cycle (registered FIFO write).
- dout_data is stable while dout_valid & !dout_ready.

Decomposition:
- Shared wb package: CTI_CLASSIC=000, CTI_INC=010, CTI_EOB=111, BTE_LINEAR=00, state enum.
- One sub-module: sync_fifo (params width, depth). Synchronous reset; registered count; push/pop/full/empty.

Test Plan:
- base 0x100, len 8, ROM model (ack next cycle, classic gaps), dout_ready=1 -> one burst. Addresses 0x100..0x11C; cti 010x7 then 111; 8 words in order; done once; error 0.
- len 20, burst_len 8 -> bursts of 8, 8, 4. Last beat of each burst cti 111; idle cycle between bursts; 20 words out.
- len 1 -> single classic cycle (cti 000, adr = base). One word; done pulse.
- dout_ready=0, len 32, fifo_depth 16 -> two bursts fill the FIFO, then the master stalls in WAIT_SPACE with cyc 0. Releasing ready resumes; all 32 words delivered; no loss.
- err_i on beat 3 of 8 -> error sticky; 2 words delivered; done pulses; cyc drops. Next start clears error.
- wb_rst asserted mid-burst -> cyc=0, dout_valid=0, busy=0 next cycle. start with len 0 -> done only, no cyc.
